// File: rtl/serv_bus_pkg.sv
// rtl/serv_bus_pkg.sv - shared types and constants for the serv bus arbiter
package serv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic REQ_IBUS = 1'b0;
  localparam logic REQ_DBUS = 1'b1;

  localparam logic [3:0] WB_SEL_ALL = 4'hf;

endpackage

// File: rtl/serv_bus_if.sv
// rtl/serv_bus_if.sv - ibus, dbus and wishbone signals seen by the arbiter
interface serv_bus_if;

  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic        o_ibus_err;

  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic        o_dbus_err;

  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;

  modport master (
    input  i_ibus_adr, i_ibus_cyc,
    output o_ibus_rdt, o_ibus_ack, o_ibus_err,
    input  i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    output o_dbus_rdt, o_dbus_ack, o_dbus_err,
    output o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    input  i_wb_rdt, i_wb_ack
  );

  modport slave (
    output i_ibus_adr, i_ibus_cyc,
    input  o_ibus_rdt, o_ibus_ack, o_ibus_err,
    output i_dbus_adr, i_dbus_dat, i_dbus_sel, i_dbus_we, i_dbus_cyc,
    input  o_dbus_rdt, o_dbus_ack, o_dbus_err,
    input  o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb,
    output i_wb_rdt, i_wb_ack
  );

endinterface

// File: rtl/serv_bus_timeout.sv
// rtl/serv_bus_timeout.sv - watchdog counting granted cycles without an ack
module serv_bus_timeout #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] ONE = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] count;
  logic [TIMEOUT_W-1:0] count_inc;

  assign count_inc = count + ONE;

  // Count stalled grant cycles; cleared whenever no grant is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc;
    end
  end

  // Fires on the stalled cycle that would bring the count to all-ones,
  // so a grant lasts 2**TIMEOUT_W-1 cycles before it is abandoned.
  assign expired = en && (&count_inc);

endmodule

// File: rtl/serv_bus_arbiter.sv
// rtl/serv_bus_arbiter.sv - round-robin ibus/dbus arbiter onto one wishbone master
module serv_bus_arbiter #(
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       i_rst_n,
  serv_bus_if.master bus
);
  import serv_bus_pkg::*;

  state_t state;
  logic   last_grant;
  logic   granted;
  logic   wd_expired;

  assign granted = (state == GNT_I) || (state == GNT_D);

  serv_bus_timeout #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .clr     (!granted),
    .en      (granted && !bus.i_wb_ack),
    .expired (wd_expired)
  );

  // Arbitration FSM; every output is a register so the bus sees clean edges.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      last_grant     <= REQ_DBUS;
      bus.o_ibus_rdt <= '0;
      bus.o_ibus_ack <= 1'b0;
      bus.o_ibus_err <= 1'b0;
      bus.o_dbus_rdt <= '0;
      bus.o_dbus_ack <= 1'b0;
      bus.o_dbus_err <= 1'b0;
      bus.o_wb_adr   <= '0;
      bus.o_wb_dat   <= '0;
      bus.o_wb_sel   <= '0;
      bus.o_wb_we    <= 1'b0;
      bus.o_wb_cyc   <= 1'b0;
      bus.o_wb_stb   <= 1'b0;
    end else begin
      // Responses are single-cycle pulses; only a completing grant raises one.
      bus.o_ibus_ack <= 1'b0;
      bus.o_ibus_err <= 1'b0;
      bus.o_dbus_ack <= 1'b0;
      bus.o_dbus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_ibus_cyc && (!bus.i_dbus_cyc || last_grant == REQ_DBUS)) begin
            bus.o_wb_adr <= bus.i_ibus_adr;
            bus.o_wb_dat <= '0;
            bus.o_wb_sel <= WB_SEL_ALL;
            bus.o_wb_we  <= 1'b0;
            bus.o_wb_cyc <= 1'b1;
            bus.o_wb_stb <= 1'b1;
            last_grant   <= REQ_IBUS;
            state        <= GNT_I;
          end else if (bus.i_dbus_cyc) begin
            bus.o_wb_adr <= bus.i_dbus_adr;
            bus.o_wb_dat <= bus.i_dbus_dat;
            bus.o_wb_sel <= bus.i_dbus_sel;
            bus.o_wb_we  <= bus.i_dbus_we;
            bus.o_wb_cyc <= 1'b1;
            bus.o_wb_stb <= 1'b1;
            last_grant   <= REQ_DBUS;
            state        <= GNT_D;
          end
        end
        GNT_I: begin
          if (bus.i_wb_ack) begin
            bus.o_ibus_rdt <= bus.i_wb_rdt;
            bus.o_ibus_ack <= 1'b1;
            bus.o_wb_cyc   <= 1'b0;
            bus.o_wb_stb   <= 1'b0;
            state          <= RESP;
          end else if (!bus.i_ibus_cyc) begin
            bus.o_wb_cyc <= 1'b0;
            bus.o_wb_stb <= 1'b0;
            state        <= IDLE;
          end else if (wd_expired) begin
            bus.o_ibus_err <= 1'b1;
            bus.o_wb_cyc   <= 1'b0;
            bus.o_wb_stb   <= 1'b0;
            state          <= RESP;
          end
        end
        GNT_D: begin
          if (bus.i_wb_ack) begin
            bus.o_dbus_rdt <= bus.i_wb_rdt;
            bus.o_dbus_ack <= 1'b1;
            bus.o_wb_cyc   <= 1'b0;
            bus.o_wb_stb   <= 1'b0;
            state          <= RESP;
          end else if (!bus.i_dbus_cyc) begin
            bus.o_wb_cyc <= 1'b0;
            bus.o_wb_stb <= 1'b0;
            state        <= IDLE;
          end else if (wd_expired) begin
            bus.o_dbus_err <= 1'b1;
            bus.o_wb_cyc   <= 1'b0;
            bus.o_wb_stb   <= 1'b0;
            state          <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// tb/tb_serv_bus_arbiter.sv - directed scoreboard bench for serv_bus_arbiter
module tb_serv_bus_arbiter;

  localparam int TW  = 4;
  localparam int TMO = (1 << TW) - 1;

  typedef struct {
    bit          is_d;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    bit          we;
    int          ack_at;
    logic [31:0] rdt;
    bit          err;
    int          len;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];
  logic [31:0] last_d_rdt;

  serv_bus_if bus ();

  serv_bus_arbiter #(
    .TIMEOUT_W (TW)
  ) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.o_ibus_ack, bus.o_ibus_err, bus.o_dbus_ack, bus.o_dbus_err};
  endfunction

  task automatic drive_i(input logic [31:0] adr);
    bus.i_ibus_adr = adr;
    bus.i_ibus_cyc = 1'b1;
  endtask

  task automatic drive_d(input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input bit we);
    bus.i_dbus_adr = adr;
    bus.i_dbus_dat = dat;
    bus.i_dbus_sel = sel;
    bus.i_dbus_we  = we;
    bus.i_dbus_cyc = 1'b1;
  endtask

  task automatic push(input bit is_d, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit we, input int ack_at,
                      input logic [31:0] rdt);
    exp_t e;
    e.is_d   = is_d;
    e.adr    = adr;
    e.dat    = is_d ? dat : 32'h0;
    e.sel    = is_d ? sel : 4'hf;
    e.we     = is_d ? we : 1'b0;
    e.ack_at = ack_at;
    e.rdt    = rdt;
    e.err    = (ack_at < 1) || (ack_at > TMO);
    e.len    = e.err ? TMO : ack_at;
    sb.push_back(e);
  endtask

  // Plays the slave for the next granted transaction and checks it against the scoreboard.
  task automatic serve(input bit drop);
    exp_t e;
    int k;
    int fbad;
    bit resp;
    logic [3:0] flags;
    logic [3:0] want;
    k = 0;
    while (!bus.o_wb_cyc && k < 8) begin
      tick();
      k++;
    end
    check("grant_seen", bus.o_wb_cyc, 1'b1);
    e = sb.pop_front();
    k = 0;
    fbad = 0;
    resp = 1'b0;
    flags = 4'b0;
    while (!resp && bus.o_wb_cyc && k < 40) begin
      k++;
      if (bus.o_wb_adr !== e.adr || bus.o_wb_dat !== e.dat || bus.o_wb_sel !== e.sel ||
          bus.o_wb_we !== e.we || bus.o_wb_stb !== 1'b1)
        fbad++;
      if (k == e.ack_at) begin
        bus.i_wb_ack = 1'b1;
        bus.i_wb_rdt = e.rdt;
      end
      tick();
      bus.i_wb_ack = 1'b0;
      bus.i_wb_rdt = $urandom();
      flags = flags_now();
      resp = |flags;
    end
    check("grant_len", k, e.len);
    check("fields_stable", fbad, 0);
    want = e.is_d ? (e.err ? 4'b0001 : 4'b0010) : (e.err ? 4'b0100 : 4'b1000);
    check("resp_flags", flags, want);
    check("cyc_low_resp", {bus.o_wb_cyc, bus.o_wb_stb}, 2'b00);
    if (!e.err)
      check("rdt", e.is_d ? bus.o_dbus_rdt : bus.o_ibus_rdt, e.rdt);
    if (!e.err && e.is_d)
      last_d_rdt = e.rdt;
    if (drop) begin
      bus.i_ibus_cyc = 1'b0;
      bus.i_dbus_cyc = 1'b0;
    end
    tick();
    check("pulse_end", flags_now(), 4'b0);
    check("cyc_low_idle", bus.o_wb_cyc, 1'b0);
    if (!e.err)
      check("rdt_hold", e.is_d ? bus.o_dbus_rdt : bus.o_ibus_rdt, e.rdt);
  endtask

  initial begin
    total = 0;
    bad = 0;
    last_d_rdt = 32'h0;
    rst_n = 1'b0;
    bus.i_ibus_adr = '0;
    bus.i_ibus_cyc = 1'b0;
    bus.i_dbus_adr = '0;
    bus.i_dbus_dat = '0;
    bus.i_dbus_sel = '0;
    bus.i_dbus_we  = 1'b0;
    bus.i_dbus_cyc = 1'b0;
    bus.i_wb_rdt   = '0;
    bus.i_wb_ack   = 1'b0;

    tick();
    tick();
    check("rst_cyc_stb", {bus.o_wb_cyc, bus.o_wb_stb}, 2'b00);
    check("rst_flags", flags_now(), 4'b0);
    check("rst_wb_fields", {bus.o_wb_sel, bus.o_wb_we}, 5'b0);
    check("rst_wb_adr", bus.o_wb_adr, 32'h0);
    check("rst_ibus_rdt", bus.o_ibus_rdt, 32'h0);
    check("rst_dbus_rdt", bus.o_dbus_rdt, 32'h0);
    rst_n = 1'b1;

    // Both requesters held from reset: ibus, dbus, ibus, dbus.
    drive_i(32'h0000_0200);
    drive_d(32'h0000_3000, 32'h1122_3344, 4'b1100, 1'b1);
    push(1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0, 1, 32'h0000_00a1);
    push(1'b1, 32'h0000_3000, 32'h1122_3344, 4'b1100, 1'b1, 2, 32'h0000_00b1);
    push(1'b0, 32'h0000_0200, 32'h0, 4'h0, 1'b0, 1, 32'h0000_00a2);
    push(1'b1, 32'h0000_3000, 32'h1122_3344, 4'b1100, 1'b1, 3, 32'h0000_00b2);
    tick();
    check("rr_latency", bus.o_wb_cyc, 1'b1);
    serve(1'b0);
    serve(1'b0);
    serve(1'b0);
    serve(1'b1);

    // Ibus read.
    drive_i(32'h0000_0100);
    push(1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 3, 32'h0000_0013);
    tick();
    check("ibus_latency", bus.o_wb_cyc, 1'b1);
    serve(1'b1);

    // Dbus store.
    drive_d(32'h0000_2000, 32'hdead_beef, 4'b0011, 1'b1);
    push(1'b1, 32'h0000_2000, 32'hdead_beef, 4'b0011, 1'b1, 2, 32'h0000_5a5a);
    tick();
    check("dbus_latency", bus.o_wb_cyc, 1'b1);
    serve(1'b1);

    // Slave never acks: watchdog error, then a normal ibus fetch.
    drive_d(32'h0000_4000, 32'h0, 4'hf, 1'b0);
    push(1'b1, 32'h0000_4000, 32'h0, 4'hf, 1'b0, 0, 32'h0);
    serve(1'b1);
    drive_i(32'h0000_0104);
    push(1'b0, 32'h0000_0104, 32'h0, 4'h0, 1'b0, 2, 32'h0000_0093);
    serve(1'b1);

    // Ack on the last cycle before expiry wins.
    drive_d(32'h0000_4004, 32'h0, 4'hf, 1'b0);
    push(1'b1, 32'h0000_4004, 32'h0, 4'hf, 1'b0, TMO, 32'h0000_cafe);
    serve(1'b1);

    // Abort two cycles into the grant; a late ack is ignored.
    drive_d(32'h0000_5000, 32'h0, 4'hf, 1'b0);
    tick();
    check("abort_grant", bus.o_wb_cyc, 1'b1);
    tick();
    bus.i_dbus_cyc = 1'b0;
    tick();
    check("abort_cyc_drop", bus.o_wb_cyc, 1'b0);
    check("abort_flags", flags_now(), 4'b0);
    bus.i_wb_ack = 1'b1;
    bus.i_wb_rdt = 32'hbad0_bad0;
    tick();
    bus.i_wb_ack = 1'b0;
    check("late_ack_flags", flags_now(), 4'b0);
    check("late_ack_rdt", bus.o_dbus_rdt, last_d_rdt);
    check("late_ack_cyc", bus.o_wb_cyc, 1'b0);

    // Reset in the middle of a grant.
    drive_i(32'h0000_0180);
    tick();
    check("rst_mid_grant", bus.o_wb_cyc, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_cyc", {bus.o_wb_cyc, bus.o_wb_stb}, 2'b00);
    check("rst_async_flags", flags_now(), 4'b0);
    check("rst_async_rdt", bus.o_ibus_rdt, 32'h0);
    bus.i_ibus_cyc = 1'b0;
    tick();
    tick();
    check("rst_held_cyc", bus.o_wb_cyc, 1'b0);
    rst_n = 1'b1;
    drive_i(32'h0000_01c0);
    push(1'b0, 32'h0000_01c0, 32'h0, 4'h0, 1'b0, 2, 32'h0010_0073);
    tick();
    check("post_rst_latency", bus.o_wb_cyc, 1'b1);
    serve(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
